// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encodings, domain indices, helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pll_seq_pkg;

  // Sequencer states; encodings are visible on seq_state for debug.
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    LOST      = 3'd5
  } seq_state_e;

  // Domain reset bit positions, in release order.
  localparam int DOM_SDRAM = 0;
  localparam int DOM_MEM   = 1;
  localparam int DOM_CPU   = 2;
  localparam int DOM_COPRO = 3;

  // Largest of four values; sizes the shared cycle counter.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Synchronises raw PLL lock and declares lock loss after LOSS_FILTER consecutive unlocked samples.
// Latency: lock_s trails pll_locked by 2 cycles; lock_lost is combinational on the synchronised sample.
// Backpressure: none; free-running, loss counting only while enable is high.
module pll_lock_filter #(
  parameter int LOSS_FILTER = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic pll_locked,
  input  logic enable,
  output logic lock_s,
  output logic lock_lost
);

  localparam int              LW   = $clog2(LOSS_FILTER) + 1;
  localparam logic [LW-1:0]   LAST = LW'(LOSS_FILTER - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [LW-1:0] lcnt_q;
  logic [LW-1:0] lcnt_d;

  // Two-flop synchroniser for the asynchronous PLL lock signal.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  // Consecutive-unlocked counter; cleared by any locked sample or when filtering is disabled.
  always_comb begin
    lcnt_d = '0;
    if (enable && !sync2_q) begin
      lcnt_d = (lcnt_q == LAST) ? lcnt_q : lcnt_q + 1'b1;
    end
  end

  // Loss counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) lcnt_q <= '0;
    else       lcnt_q <= lcnt_d;
  end

  assign lock_s    = sync2_q;
  // The current unlocked sample is the LOSS_FILTER-th in a row.
  assign lock_lost = enable && !sync2_q && (lcnt_q == LAST);

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses PLL reset, qualifies lock, then releases domain resets in order; re-locks on loss or request.
// Latency: all outputs registered; lock input seen 2 cycles late through the synchroniser.
// Backpressure: none; relock_req is a single-cycle pulse honoured only in RELEASE/RUN.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_DOMAINS    = 4,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGE_GAP      = 16,
  parameter int LOSS_FILTER    = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pll_locked,
  input  logic                   relock_req,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic [7:0]             relock_count,
  output logic [2:0]             seq_state
);

  localparam int            CNT_MAX  = max4(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, STAGE_GAP);
  localparam int            CW       = $clog2(CNT_MAX) + 1;
  localparam int            IW       = $clog2(NUM_DOMAINS) + 1;
  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DOMAINS - 1);

  seq_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   pll_rst_q, pll_rst_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   ready_q, ready_d;
  logic [7:0]             rc_q, rc_d;
  logic [7:0]             rc_inc;
  logic                   lock_s;
  logic                   lock_lost;
  logic                   loss_en;

  // Loss filtering only matters once domains start coming out of reset.
  assign loss_en = (state_q == RELEASE) || (state_q == RUN);
  assign rc_inc  = (rc_q == 8'hFF) ? rc_q : rc_q + 8'd1;

  pll_lock_filter #(
    .LOSS_FILTER (LOSS_FILTER)
  ) u_lock_filter (
    .clock      (clock),
    .reset      (reset),
    .pll_locked (pll_locked),
    .enable     (loss_en),
    .lock_s     (lock_s),
    .lock_lost  (lock_lost)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= PLL_RST;
      cnt_q     <= '0;
      idx_q     <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= '1;
      ready_q   <= 1'b0;
      rc_q      <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pll_rst_q <= pll_rst_d;
      dom_q     <= dom_d;
      ready_q   <= ready_d;
      rc_q      <= rc_d;
    end
  end

  // Next-state and next-output logic for the lock/release sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pll_rst_d = pll_rst_q;
    dom_d     = dom_q;
    ready_d   = ready_q;
    rc_d      = rc_q;

    case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d   = WAIT_LOCK;
          pll_rst_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d   = PLL_RST;
          pll_rst_d = 1'b1;
          cnt_d     = '0;
          rc_d      = rc_inc;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STABLE: begin
        // Any glitch here restarts the lock wait with a fresh timeout.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = IW'(DOM_SDRAM);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RELEASE: begin
        // Loss takes priority over a release due in the same cycle.
        if (lock_lost || relock_req) begin
          state_d = LOST;
          dom_d   = '1;
          ready_d = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (idx_q == IW'(i)) dom_d[i] = 1'b0;
          end
          if (idx_q == IDX_LAST) begin
            state_d = RUN;
            ready_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RUN: begin
        if (lock_lost || relock_req) begin
          state_d = LOST;
          dom_d   = '1;
          ready_d = 1'b0;
          cnt_d   = '0;
        end
      end

      LOST: begin
        state_d   = PLL_RST;
        pll_rst_d = 1'b1;
        cnt_d     = '0;
        rc_d      = rc_inc;
      end

      default: begin
        state_d   = PLL_RST;
        pll_rst_d = 1'b1;
        dom_d     = '1;
        ready_d   = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  assign pll_rst      = pll_rst_q;
  assign domain_rst   = dom_q;
  assign ready        = ready_q;
  assign relock_count = rc_q;
  assign seq_state    = state_q;

endmodule
